// File: rtl/fsm_alu_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_alu_ctrl
// Multi-cycle control sequencer for integer ALU instructions (OP, OP-IMM,
// OP-32, OP-IMM-32). An instruction word and its one-hot decoded opcode are
// captured on start; the block then walks DECODE -> READ -> EXEC -> WB, or
// DECODE -> ERR when the encoding is rejected. READ and EXEC are stretched by
// REG_LAT / ALU_LAT cycles so the sequencer can match a slow regfile or ALU.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   start                       request, only looked at while idle
//   ins[31:0], code[CODE_W-1:0] instruction word and one-hot opcode
//   rs1_addr/rs2_addr/rd_addr   register addresses of the captured word
//   func3                       captured ins[14:12]
//   sub_sra, sel_alu_b, word_op ALU controls (subtract/arith shift, imm
//                               operand, 32-bit W-variant)
//   load_rs1/load_rs2/load_alu  datapath register enables
//   load_regfile, load_pc       regfile write / PC write enables
//   sel_pc_next                 PC mux select, 1 = PC+4
//   busy, done, illegal         status; done/illegal are 1-cycle pulses
// All outputs are Moore: decoded from the state and the captured word only.
// ---------------------------------------------------------------------------
module fsm_alu_ctrl #(
    parameter int XLEN        = 64,
    parameter int CODE_W      = 32,
    parameter int OP_BIT      = 12,
    parameter int OPIMM_BIT   = 11,
    parameter int OPIMM32_BIT = 13,
    parameter int OP32_BIT    = 14,
    parameter int REG_LAT     = 1,
    parameter int ALU_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       ins,
    input  logic [CODE_W-1:0] code,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    output logic [4:0]        rd_addr,
    output logic [2:0]        func3,
    output logic              sub_sra,
    output logic              sel_alu_b,
    output logic              word_op,
    output logic              load_rs1,
    output logic              load_rs2,
    output logic              load_alu,
    output logic              load_regfile,
    output logic              load_pc,
    output logic              sel_pc_next,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    localparam logic [3:0] REG_CNT_INIT = 4'(REG_LAT - 1);
    localparam logic [3:0] ALU_CNT_INIT = 4'(ALU_LAT - 1);
    localparam bit         RV32         = (XLEN == 32);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    // Only ins[31:7] matters: the opcode field is already decoded into code.
    logic [31:7] r_ins;
    // Captured opcode bits, ordered {OP-32, OP-IMM-32, OP, OP-IMM}.
    logic [3:0]  r_kind;

    logic        w_op;
    logic        w_opimm;
    logic        w_opimm32;
    logic        w_op32;
    logic        w_onehot;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic        w_f7_ok;
    logic        w_illegal;
    logic        w_unused_ok;

    // The remaining code bits and ins[6:0] are intentionally ignored.
    assign w_unused_ok = &{1'b0, ins[6:0], code};

    assign w_opimm   = r_kind[0];
    assign w_op      = r_kind[1];
    assign w_opimm32 = r_kind[2];
    assign w_op32    = r_kind[3];
    assign w_onehot  = (r_kind == 4'b0001) || (r_kind == 4'b0010) ||
                       (r_kind == 4'b0100) || (r_kind == 4'b1000);
    assign w_f7      = r_ins[31:25];
    assign w_f3      = r_ins[14:12];
    assign w_f7_ok   = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ins   <= '0;
            r_kind  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && start) begin
                r_ins  <= ins[31:7];
                r_kind <= {code[OP32_BIT], code[OPIMM32_BIT], code[OP_BIT], code[OPIMM_BIT]};
            end
        end
    end

    // Legality of the captured word; only consumed in DECODE.
    always_comb begin
        w_illegal = 1'b0;
        if (!w_onehot) begin
            w_illegal = 1'b1;
        end else if (w_op) begin
            w_illegal = !w_f7_ok ||
                        ((w_f7 == 7'b0100000) && !(w_f3 == 3'b000 || w_f3 == 3'b101));
        end else if (w_opimm) begin
            // Shift immediates: ins[25] is shamt[5], only meaningful on RV64.
            if (w_f3 == 3'b001) begin
                w_illegal = (r_ins[31:26] != 6'b000000) || (RV32 && r_ins[25]);
            end else if (w_f3 == 3'b101) begin
                w_illegal = ((r_ins[31:26] != 6'b000000) && (r_ins[31:26] != 6'b010000)) ||
                            (RV32 && r_ins[25]);
            end
        end else begin
            // W-variants (OP-32 / OP-IMM-32)
            if (RV32) begin
                w_illegal = 1'b1;
            end else if (!(w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101)) begin
                w_illegal = 1'b1;
            end else if (w_op32 || w_f3 != 3'b000) begin
                // addiw carries an immediate in ins[31:20], so it is exempt.
                w_illegal = !w_f7_ok || ((w_f7 == 7'b0100000) && (w_f3 == 3'b001));
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_state_next = S_ERR;
                end else begin
                    w_state_next = S_READ;
                    w_cnt_next   = REG_CNT_INIT;
                end
            end
            S_READ: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_EXEC;
                    w_cnt_next   = ALU_CNT_INIT;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_WB;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_WB:    w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rs1_addr     = '0;
        rs2_addr     = '0;
        rd_addr      = '0;
        func3        = '0;
        sub_sra      = 1'b0;
        sel_alu_b    = 1'b0;
        word_op      = 1'b0;
        load_rs1     = 1'b0;
        load_rs2     = 1'b0;
        load_alu     = 1'b0;
        load_regfile = 1'b0;
        load_pc      = 1'b0;
        sel_pc_next  = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        illegal      = 1'b0;
        // Fields are presented only while an instruction is in flight.
        if (r_state != S_IDLE) begin
            rs1_addr  = r_ins[19:15];
            rs2_addr  = r_ins[24:20];
            rd_addr   = r_ins[11:7];
            func3     = w_f3;
            // Register forms use ins[30] for sub and sra; immediate forms only
            // for srai, since addi's ins[30] is immediate data.
            sub_sra   = r_ins[30] &&
                        (((w_op || w_op32) && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                         ((w_opimm || w_opimm32) && (w_f3 == 3'b101)));
            sel_alu_b = w_opimm || w_opimm32;
            word_op   = w_op32 || w_opimm32;
        end
        case (r_state)
            S_READ: begin
                load_rs1 = (r_cnt == 4'd0);
                load_rs2 = (r_cnt == 4'd0);
            end
            S_EXEC: load_alu = (r_cnt == 4'd0);
            S_WB: begin
                load_pc      = 1'b1;
                sel_pc_next  = 1'b1;
                done         = 1'b1;
                load_regfile = (r_ins[11:7] != 5'd0);
            end
            S_ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
